// File: rtl/fir_package.sv
// fir_package: shared types, state encoding and width helper for the FIR datapath.
package fir_package;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fir_datapath_state_t;

    typedef struct packed {
        logic [31:0] len;
    } fir_datapath_ctrl_t;

    typedef struct packed {
        logic                done;
        fir_datapath_state_t state;
    } fir_datapath_flags_t;

    function automatic int fir_out_width(input int data_width, input int nb_taps);
        return 2 * data_width + $clog2(nb_taps);
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: registered signed reduction of N packed operands with enable.
module fir_adder_tree #(
    parameter int N     = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 34
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [N*IN_W-1:0]       in_i,
    output logic signed [OUT_W-1:0] sum_o
);

    logic signed [OUT_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++)
            sum = sum + OUT_W'($signed(in_i[k*IN_W +: IN_W]));
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            sum_o <= '0;
        else if (clear_i)
            sum_o <= '0;
        else if (en_i)
            sum_o <= sum;

endmodule

// File: rtl/fir_datapath_pipe.sv
// fir_datapath_pipe: direct-form FIR stage, taps latched per run, then x stream in
// and y stream out through a two-stage multiply / add pipeline with backpressure.
module fir_datapath_pipe
    import fir_package::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NB_TAPS    = 4,
    parameter int LEN_WIDTH  = 16,
    localparam int OUT_WIDTH = fir_out_width(DATA_WIDTH, NB_TAPS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [LEN_WIDTH-1:0]          len_i,
    input  logic [NB_TAPS*DATA_WIDTH-1:0] h_data_i,
    input  logic                          h_valid_i,
    output logic                          h_ready_o,
    input  logic [DATA_WIDTH-1:0]         x_data_i,
    input  logic                          x_valid_i,
    output logic                          x_ready_o,
    output logic signed [OUT_WIDTH-1:0]   y_data_o,
    output logic                          y_valid_o,
    input  logic                          y_ready_i,
    output logic                          done_o
);

    localparam int PW = 2 * DATA_WIDTH;

    fir_datapath_flags_t          flags_q;
    fir_datapath_ctrl_t           ctrl_q;
    logic [LEN_WIDTH-1:0]         cnt_q;
    logic signed [DATA_WIDTH-1:0] h_q [NB_TAPS];
    logic signed [DATA_WIDTH-1:0] d_q [NB_TAPS];
    logic signed [DATA_WIDTH-1:0] dn  [NB_TAPS];
    logic signed [PW-1:0]         prod [NB_TAPS];
    logic [NB_TAPS*PW-1:0]        prod_q;
    logic                         v1_q, v2_q, en, x_hs, h_hs;

    // The whole pipeline freezes only while a y sample is offered and refused.
    assign en        = ~(v2_q & ~y_ready_i);
    assign h_ready_o = flags_q.state == IDLE;
    assign x_ready_o = (flags_q.state == RUN) & en;
    assign y_valid_o = v2_q;
    assign done_o    = flags_q.done;
    assign h_hs      = h_valid_i & h_ready_o;
    assign x_hs      = x_valid_i & x_ready_o;

    always_comb begin
        dn[0] = x_data_i;
        for (int k = 1; k < NB_TAPS; k++)
            dn[k] = d_q[k-1];
        for (int k = 0; k < NB_TAPS; k++)
            prod[k] = h_q[k] * dn[k];
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            flags_q <= '{done: 1'b0, state: IDLE};
            ctrl_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NB_TAPS; k++) begin
                h_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else if (clear_i) begin
            flags_q <= '{done: 1'b0, state: IDLE};
            ctrl_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NB_TAPS; k++) begin
                h_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            flags_q.done <= 1'b0;
            if (h_hs) begin
                for (int k = 0; k < NB_TAPS; k++) begin
                    h_q[k] <= h_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    d_q[k] <= '0;
                end
                ctrl_q.len    <= 32'(len_i);
                cnt_q         <= '0;
                flags_q.state <= (len_i != '0) ? RUN : DONE;
                flags_q.done  <= len_i == '0;
            end else if (x_hs) begin
                d_q   <= dn;
                cnt_q <= cnt_q + 1'b1;
                if (32'(cnt_q) + 32'd1 == ctrl_q.len)
                    flags_q.state <= DRAIN;
            end else if (flags_q.state == DRAIN && !v1_q && !v2_q) begin
                flags_q.state <= DONE;
                flags_q.done  <= 1'b1;
            end else if (flags_q.state == DONE) begin
                flags_q.state <= IDLE;
                for (int k = 0; k < NB_TAPS; k++)
                    h_q[k] <= '0;
            end
        end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            prod_q <= '0;
        end else if (clear_i) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            prod_q <= '0;
        end else if (en) begin
            v1_q <= x_hs;
            v2_q <= v1_q;
            if (x_hs)
                for (int k = 0; k < NB_TAPS; k++)
                    prod_q[k*PW +: PW] <= prod[k];
        end

    // Only valid S1 data advances into S2, so y_data_o holds its last sample.
    fir_adder_tree #(
        .N     (NB_TAPS),
        .IN_W  (PW),
        .OUT_W (OUT_WIDTH)
    ) u_tree (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .en_i    (en & v1_q),
        .in_i    (prod_q),
        .sum_o   (y_data_o)
    );

endmodule

// File: tb/tb_fir_datapath_pipe.sv
// tb_fir_datapath_pipe: directed-vector bench for fir_datapath_pipe (4 taps x 16 bit).
module tb_fir_datapath_pipe;

    logic               clk_i, rst_i, clear_i;
    logic [15:0]        len_i;
    logic [63:0]        h_data_i;
    logic               h_valid_i, h_ready_o;
    logic [15:0]        x_data_i;
    logic               x_valid_i, x_ready_o;
    logic signed [33:0] y_data_o;
    logic               y_valid_o, y_ready_i, done_o;

    int     n_vec, n_err, cyc, hs_cyc, done_cyc, xhs_cyc, yv_cyc;
    int     done_cnt, xrdy_cnt, ymode, bp_i;
    int     xv[$];
    longint ys[$];
    longint exp_y[$];
    bit     stall_prev;
    logic [33:0] prev_y;

    fir_datapath_pipe dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .len_i     (len_i),
        .h_data_i  (h_data_i),
        .h_valid_i (h_valid_i),
        .h_ready_o (h_ready_o),
        .x_data_i  (x_data_i),
        .x_valid_i (x_valid_i),
        .x_ready_o (x_ready_o),
        .y_data_o  (y_data_o),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready_i),
        .done_o    (done_o)
    );

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // y_ready pattern: 0 always ready, 1 toggles 1,0,0,1..., 2 never ready
    initial begin
        y_ready_i = 1;
        bp_i = 0;
        forever begin
            @(posedge clk_i);
            #1;
            y_ready_i = (ymode == 0) ? 1'b1 : (ymode == 2) ? 1'b0 : (bp_i % 4 == 0 || bp_i % 4 == 3);
            bp_i++;
        end
    end

    always @(negedge clk_i)
        if (!rst_i) begin
            if (x_valid_i && x_ready_o && xhs_cyc < 0) xhs_cyc = cyc;
            if (x_ready_o) xrdy_cnt++;
            if (y_valid_o && yv_cyc < 0) yv_cyc = cyc;
            if (y_valid_o && y_ready_i) ys.push_back(longint'(y_data_o));
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (y_valid_o && !y_ready_i) check("x_ready_in_stall", 64'(x_ready_o), 0);
            if (stall_prev && y_valid_o) check("y_hold_in_stall", 64'(y_data_o), 64'(prev_y));
            stall_prev = y_valid_o && !y_ready_i;
            prev_y = y_data_o;
        end

    task automatic start_run(input logic [63:0] taps, input int len);
        bit ok;
        int n;
        ys.delete();
        done_cnt = 0; xrdy_cnt = 0; xhs_cyc = -1; yv_cyc = -1;
        h_data_i = taps; len_i = 16'(len); h_valid_i = 1;
        n = 0;
        do begin
            @(negedge clk_i);
            ok = h_ready_o;
            hs_cyc = cyc;
            @(posedge clk_i);
            #1;
            n++;
        end while (!ok && n < 20);
        h_valid_i = 0;
        check("h_handshake", 64'(ok), 1);
    endtask

    task automatic send_x(input int cnt);
        bit ok;
        int n;
        for (int i = 0; i < cnt; i++) begin
            x_valid_i = 1;
            x_data_i = 16'(xv[i]);
            n = 0;
            do begin
                @(negedge clk_i);
                ok = x_ready_o;
                @(posedge clk_i);
                #1;
                n++;
            end while (!ok && n < 50);
            if (!ok) check("x_accept", 64'(ok), 1);
        end
        x_valid_i = 0;
    endtask

    task automatic wait_done(input int n_y);
        bit seen;
        int n;
        seen = 0;
        n = 0;
        while (!seen && n < 300) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                check("y_count_at_done", 64'(ys.size()), 64'(n_y));
            end
            n++;
        end
        check("done_seen", 64'(seen), 1);
        repeat (4) @(posedge clk_i);
        #1;
        check("done_once", 64'(done_cnt), 1);
    endtask

    task automatic check_ys(input string tag);
        check({tag, "_len"}, 64'(ys.size()), 64'(exp_y.size()));
        for (int i = 0; i < exp_y.size(); i++)
            check(tag, (i < ys.size()) ? 64'(ys[i]) : 64'hdead, 64'(exp_y[i]));
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; ymode = 0; stall_prev = 0; prev_y = '0;
        rst_i = 1; clear_i = 0; h_valid_i = 0; x_valid_i = 0; h_data_i = 0; len_i = 0; x_data_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_h_ready", 64'(h_ready_o), 1);
        check("rst_x_ready", 64'(x_ready_o), 0);
        check("rst_y_valid", 64'(y_valid_o), 0);
        check("rst_y_data", 64'(y_data_o), 0);
        check("rst_done", 64'(done_o), 0);
        rst_i = 0;
        @(posedge clk_i);
        #1;

        // impulse response
        start_run({16'd4, 16'd3, 16'd2, 16'd1}, 6);
        xv = '{1, 0, 0, 0, 0, 0};
        send_x(6);
        wait_done(6);
        check("impulse_latency", 64'(yv_cyc - xhs_cyc), 2);
        exp_y = '{1, 2, 3, 4, 0, 0};
        check_ys("impulse_y");

        // signed extremes
        start_run({4{16'h8000}}, 4);
        xv = '{-32768, -32768, -32768, -32768};
        send_x(4);
        wait_done(4);
        exp_y = '{64'sd1 <<< 30, 64'sd1 <<< 31, 64'sd3 <<< 30, 64'sd1 <<< 32};
        check_ys("extreme_y");

        // backpressure
        ymode = 1;
        start_run({4{16'd1}}, 8);
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_x(8);
        wait_done(8);
        exp_y = '{1, 3, 6, 10, 14, 18, 22, 26};
        check_ys("bp_y");
        ymode = 0;

        // zero-length run
        start_run({4{16'd1}}, 0);
        wait_done(0);
        check("len0_done_delay", 64'(done_cyc - hs_cyc), 1);
        check("len0_x_ready", 64'(xrdy_cnt), 0);
        check("len0_y_count", 64'(ys.size()), 0);

        // clear mid-run with two samples in flight
        ymode = 2;
        start_run({4{16'd1}}, 4);
        xv = '{3, 4};
        send_x(2);
        clear_i = 1;
        @(negedge clk_i);
        check("abort_inflight", 64'(y_valid_o), 1);
        @(posedge clk_i);
        #1;
        clear_i = 0;
        @(negedge clk_i);
        check("abort_y_valid", 64'(y_valid_o), 0);
        check("abort_h_ready", 64'(h_ready_o), 1);
        repeat (5) @(posedge clk_i);
        #1;
        check("abort_no_done", 64'(done_cnt), 0);
        check("abort_no_y", 64'(ys.size()), 0);
        ymode = 0;
        @(posedge clk_i);
        #1;
        start_run({16'd0, 16'd0, 16'd0, 16'd2}, 1);
        xv = '{5};
        send_x(1);
        wait_done(1);
        exp_y = '{10};
        check_ys("after_abort_y");

        // async reset between edges
        ymode = 2;
        start_run({4{16'd1}}, 4);
        xv = '{1, 2};
        send_x(2);
        #2;
        rst_i = 1;
        #1;
        check("arst_y_valid", 64'(y_valid_o), 0);
        check("arst_h_ready", 64'(h_ready_o), 1);
        check("arst_x_ready", 64'(x_ready_o), 0);
        check("arst_y_data", 64'(y_data_o), 0);
        check("arst_done", 64'(done_o), 0);
        rst_i = 0;
        ymode = 0;
        repeat (2) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
